// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: packs the renderer's RGB444 raster stream into 8-pixel
// groups and writes each group to the DDR3 framebuffer through the MIG UI.
// Each group becomes two 64-bit data beats followed by one write command.
// render_complete tells scan-out that the whole frame has reached DDR3.
module fb_pixel_writer #(
  parameter int ADDR_WIDTH   = 19,
  parameter int FB_PIXELS    = 307200,
  parameter int BURST_PIXELS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [11:0]           pix_data,
  output logic                  render_complete,
  output logic                  ddr3_app_en,
  output logic [2:0]            ddr3_app_cmd,
  output logic [ADDR_WIDTH-1:0] ddr3_app_addr,
  input  logic                  ddr3_app_rdy,
  output logic                  ddr3_app_wdf_wren,
  output logic [63:0]           ddr3_app_wdf_data,
  output logic                  ddr3_app_wdf_end,
  input  logic                  ddr3_app_wdf_rdy
);

  localparam int CNT_W = $clog2(BURST_PIXELS);
  localparam int GRP_W = 16 * BURST_PIXELS;
  localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(BURST_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_PIXELS - BURST_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WR_BEAT0,
    S_WR_BEAT1,
    S_WR_CMD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Only the 7 most recent pixels need to be kept: the 8th arrives on the
  // same cycle the first beat is loaded, straight from w_group_shift.
  logic [GRP_W-17:0]       r_group;
  logic [CNT_W-1:0]        r_count;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_restart_pend;
  logic                    r_render_complete;
  logic                    r_app_en;
  logic [ADDR_WIDTH-1:0]   r_app_addr;
  logic                    r_wdf_wren;
  logic [63:0]             r_wdf_data;
  logic                    r_wdf_end;

  logic                    w_pix_accept;
  logic                    w_cmd_accept;
  logic                    w_in_handshake;
  logic                    w_restart;
  logic [GRP_W-1:0]        w_group_shift;

  assign w_pix_accept   = (r_state == S_COLLECT) && pix_valid;
  assign w_cmd_accept   = (r_state == S_WR_CMD) && ddr3_app_rdy;
  assign w_in_handshake = (r_state == S_WR_BEAT0) || (r_state == S_WR_BEAT1) ||
                          (r_state == S_WR_CMD);
  // Pixel 0 of a group ends up in the top 16 bits, matching the MSB-first
  // unpacking in scan-out.
  assign w_group_shift  = {r_group, 4'h0, pix_data};

  // Next-state logic; w_restart marks a cycle that (re)initialises the frame.
  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (frame_start) begin
          w_state_next = S_COLLECT;
          w_restart    = 1'b1;
        end
      end
      S_COLLECT: begin
        if (frame_start) begin
          w_restart = 1'b1;
        end else if (pix_valid && (r_count == LAST_IDX)) begin
          w_state_next = S_WR_BEAT0;
        end
      end
      S_WR_BEAT0: begin
        if (ddr3_app_wdf_rdy) w_state_next = S_WR_BEAT1;
      end
      S_WR_BEAT1: begin
        if (ddr3_app_wdf_rdy) w_state_next = S_WR_CMD;
      end
      S_WR_CMD: begin
        if (ddr3_app_rdy) begin
          // A frame_start seen during the handshake wins over finishing the frame.
          if (r_restart_pend) begin
            w_state_next = S_COLLECT;
            w_restart    = 1'b1;
          end else if (r_addr == LAST_ADDR) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_COLLECT;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Pixel collection, frame address and frame-level flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_group           <= '0;
      r_count           <= '0;
      r_addr            <= '0;
      r_restart_pend    <= 1'b0;
      r_render_complete <= 1'b0;
    end else begin
      if (w_pix_accept) r_group <= w_group_shift[GRP_W-17:0];

      // A pixel accepted together with frame_start is pixel 0 of the new frame.
      if (w_restart)         r_count <= w_pix_accept ? CNT_W'(1) : '0;
      else if (w_pix_accept) r_count <= r_count + CNT_W'(1);

      if (w_restart)         r_addr <= '0;
      else if (w_cmd_accept) r_addr <= r_addr + ADDR_STEP;

      if (w_restart)
        r_render_complete <= 1'b0;
      else if (w_cmd_accept && (w_state_next == S_DONE))
        r_render_complete <= 1'b1;

      // Defer frame_start until the MIG handshake is finished.
      if (w_restart)
        r_restart_pend <= 1'b0;
      else if (frame_start && w_in_handshake)
        r_restart_pend <= 1'b1;
    end
  end

  // Registered MIG UI outputs, loaded on entry to each handshake state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_app_en   <= 1'b0;
      r_app_addr <= '0;
      r_wdf_wren <= 1'b0;
      r_wdf_data <= '0;
      r_wdf_end  <= 1'b0;
    end else begin
      r_app_en   <= (w_state_next == S_WR_CMD);
      r_wdf_wren <= (w_state_next == S_WR_BEAT0) || (w_state_next == S_WR_BEAT1);
      r_wdf_end  <= (w_state_next == S_WR_BEAT1);

      if ((r_state == S_COLLECT) && (w_state_next == S_WR_BEAT0))
        r_wdf_data <= w_group_shift[GRP_W-1 -: 64];
      else if ((r_state == S_WR_BEAT0) && (w_state_next == S_WR_BEAT1))
        r_wdf_data <= r_group[63:0];

      if ((r_state == S_WR_BEAT1) && (w_state_next == S_WR_CMD))
        r_app_addr <= r_addr;
    end
  end

  assign pix_ready         = (r_state == S_COLLECT);
  assign render_complete   = r_render_complete;
  assign ddr3_app_en       = r_app_en;
  assign ddr3_app_cmd      = 3'b000;
  assign ddr3_app_addr     = r_app_addr;
  assign ddr3_app_wdf_wren = r_wdf_wren;
  assign ddr3_app_wdf_data = r_wdf_data;
  assign ddr3_app_wdf_end  = r_wdf_end;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Testbench for fb_pixel_writer: random pixel streams and MIG back-pressure,
// checked by a queue-based scoreboard fed from a group-level reference model.
module tb_fb_pixel_writer;

  localparam int AW  = 19;
  localparam int FBP = 128;
  localparam int P_APP_EN = 0;
  localparam int P_BEAT0  = 1;
  localparam int P_BEAT1  = 2;
  localparam int P_RC     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic pix_valid = 1'b0;
  logic [11:0] pix_data = '0;
  logic ddr3_app_rdy = 1'b0;
  logic ddr3_app_wdf_rdy = 1'b0;
  logic pix_ready, render_complete, ddr3_app_en, ddr3_app_wdf_wren, ddr3_app_wdf_end;
  logic [2:0] ddr3_app_cmd;
  logic [AW-1:0] ddr3_app_addr;
  logic [63:0] ddr3_app_wdf_data;

  fb_pixel_writer #(.ADDR_WIDTH(AW), .FB_PIXELS(FBP), .BURST_PIXELS(8)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .render_complete(render_complete),
    .ddr3_app_en(ddr3_app_en), .ddr3_app_cmd(ddr3_app_cmd), .ddr3_app_addr(ddr3_app_addr),
    .ddr3_app_rdy(ddr3_app_rdy),
    .ddr3_app_wdf_wren(ddr3_app_wdf_wren), .ddr3_app_wdf_data(ddr3_app_wdf_data),
    .ddr3_app_wdf_end(ddr3_app_wdf_end), .ddr3_app_wdf_rdy(ddr3_app_wdf_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [63:0] b0;
    logic [63:0] b1;
    bit          last;
  } grp_t;

  int   checks = 0;
  int   errors = 0;
  grp_t exp_q[$];
  int   cmd_cycles[$];
  int   cyc = 0;
  int   frame_cmds = 0;
  int   last_cmd_addr = -1;
  int   rdy_mode = 0;        // 0: always ready, 1: random stalls, 2: driven by the stimulus
  bit   exp_rc = 1'b0;
  bit   stuck = 1'b0;

  // Reference model: pixels of the current partial group and next group address.
  logic [15:0] m_pix[8];
  int          m_cnt = 0;
  int          m_addr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_frame_start();
    m_cnt  = 0;
    m_addr = 0;
  endtask

  task automatic model_pixel(input logic [11:0] d);
    grp_t g;
    m_pix[m_cnt] = {4'h0, d};
    m_cnt++;
    if (m_cnt == 8) begin
      g.addr = m_addr;
      g.b0   = {m_pix[0], m_pix[1], m_pix[2], m_pix[3]};
      g.b1   = {m_pix[4], m_pix[5], m_pix[6], m_pix[7]};
      g.last = (m_addr == FBP - 8);
      exp_q.push_back(g);
      m_addr += 8;
      m_cnt = 0;
    end
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_frame_start();
  endtask

  // Offer one pixel and wait (bounded) until the DUT takes it.
  task automatic send_pixel(input logic [11:0] d);
    bit acc = 1'b0;
    int waited = 0;
    if (stuck) return;
    pix_valid = 1'b1;
    pix_data  = d;
    forever begin
      @(negedge clk);
      acc = pix_ready;
      tick();
      if (acc) break;
      waited++;
      if (waited > 300) break;
    end
    pix_valid = 1'b0;
    if (acc) model_pixel(d);
    else begin
      checks++;
      errors++;
      stuck = 1'b1;
      $display("FAIL pix_accept_timeout actual=not_ready required=ready");
    end
  endtask

  function automatic bit probe(input int which);
    case (which)
      P_APP_EN: return ddr3_app_en;
      P_BEAT0:  return ddr3_app_wdf_wren && !ddr3_app_wdf_end;
      P_BEAT1:  return ddr3_app_wdf_wren && ddr3_app_wdf_end;
      P_RC:     return render_complete;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (probe(which)) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=0 required=1", name);
        break;
      end
    end
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0) && (n < 500)) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Offer pixels while the DUT must refuse them.
  task automatic expect_refused(input int n, input string name);
    pix_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      pix_data = 12'($urandom_range(0, 4095));
      @(negedge clk);
      check(name, 64'(pix_ready), 64'd0);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  // MIG ready generator.
  initial begin
    forever begin
      tick();
      if (rdy_mode == 0) begin
        ddr3_app_rdy     = 1'b1;
        ddr3_app_wdf_rdy = 1'b1;
      end else if (rdy_mode == 1) begin
        ddr3_app_rdy     = ($urandom_range(0, 3) != 0);
        ddr3_app_wdf_rdy = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Monitor: observes MIG handshakes, pops the scoreboard, checks protocol.
  logic [63:0]   mon_beats[2];
  int            mon_nb = 0;
  grp_t          mon_g;
  bit            rc_next;
  bit            pv_rst = 1'b1, pv_en = 1'b0, pv_ardy = 1'b0, pv_wren = 1'b0, pv_wrdy = 1'b0;
  logic          pv_end = 1'b0;
  logic [AW-1:0] pv_addr = '0;
  logic [63:0]   pv_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!pv_rst && !rst) begin
        if (pv_en && !pv_ardy) begin
          check("app_en_held", 64'(ddr3_app_en), 64'd1);
          check("app_addr_stable", 64'(ddr3_app_addr), 64'(pv_addr));
        end
        if (pv_wren && !pv_wrdy) begin
          check("wdf_wren_held", 64'(ddr3_app_wdf_wren), 64'd1);
          check("wdf_data_stable", ddr3_app_wdf_data, pv_data);
          check("wdf_end_stable", 64'(ddr3_app_wdf_end), 64'(pv_end));
        end
      end
      if (rst) begin
        exp_q.delete();
        mon_nb = 0;
        exp_rc = 1'b0;
      end else begin
        check("render_complete", 64'(render_complete), 64'(exp_rc));
        if (ddr3_app_en || ddr3_app_wdf_wren)
          check("pix_ready_in_handshake", 64'(pix_ready), 64'd0);
        rc_next = exp_rc;
        if (ddr3_app_wdf_wren && ddr3_app_wdf_rdy) begin
          check("wdf_end_position", 64'(ddr3_app_wdf_end), 64'(mon_nb == 1));
          if (mon_nb < 2) mon_beats[mon_nb] = ddr3_app_wdf_data;
          mon_nb++;
        end
        if (ddr3_app_en && ddr3_app_rdy) begin
          check("app_cmd", 64'(ddr3_app_cmd), 64'd0);
          $display("CMD addr=%0d beat0=%016h beat1=%016h", ddr3_app_addr, mon_beats[0], mon_beats[1]);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd actual=addr_%0d required=none", ddr3_app_addr);
          end else begin
            mon_g = exp_q.pop_front();
            check("cmd_addr", 64'(ddr3_app_addr), 64'(mon_g.addr));
            check("beats_per_group", 64'(mon_nb), 64'd2);
            check("beat0", mon_beats[0], mon_g.b0);
            check("beat1", mon_beats[1], mon_g.b1);
            if (mon_g.last) rc_next = 1'b1;
          end
          cmd_cycles.push_back(cyc);
          frame_cmds++;
          last_cmd_addr = int'(ddr3_app_addr);
          mon_nb = 0;
        end
        if (frame_start) rc_next = 1'b0;
        exp_rc = rc_next;
      end
      pv_rst  = rst;
      pv_en   = ddr3_app_en;
      pv_ardy = ddr3_app_rdy;
      pv_wren = ddr3_app_wdf_wren;
      pv_wrdy = ddr3_app_wdf_rdy;
      pv_end  = ddr3_app_wdf_end;
      pv_addr = ddr3_app_addr;
      pv_data = ddr3_app_wdf_data;
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_pix_ready", 64'(pix_ready), 64'd0);
    check("rst_render_complete", 64'(render_complete), 64'd0);
    check("rst_app_en", 64'(ddr3_app_en), 64'd0);
    check("rst_app_addr", 64'(ddr3_app_addr), 64'd0);
    check("rst_wdf_wren", 64'(ddr3_app_wdf_wren), 64'd0);
    check("rst_wdf_data", ddr3_app_wdf_data, 64'd0);
    check("rst_wdf_end", 64'(ddr3_app_wdf_end), 64'd0);
    tick();
    expect_refused(3, "idle_refuses_pixels");

    // Two known groups with all rdy high; back-to-back groups take 11 cycles.
    rdy_mode = 0;
    cmd_cycles.delete();
    pulse_frame_start();
    for (int i = 1; i <= 16; i++) send_pixel(12'(i));
    drain();
    check("cmds_phase1", 64'(cmd_cycles.size()), 64'd2);
    if (cmd_cycles.size() == 2)
      check("group_period", 64'(cmd_cycles[1] - cmd_cycles[0]), 64'd11);

    // Full frame with random stalls.
    rdy_mode = 1;
    pulse_frame_start();
    frame_cmds = 0;
    for (int i = 0; i < FBP; i++) send_pixel(12'($urandom_range(0, 4095)));
    wait_for(P_RC, "render_complete");
    check("frame_cmd_count", 64'(frame_cmds), 64'(FBP / 8));
    check("frame_last_addr", 64'(last_cmd_addr), 64'(FBP - 8));
    check("scoreboard_after_frame", 64'(exp_q.size()), 64'd0);
    rdy_mode = 0;
    expect_refused(10, "done_refuses_pixels");

    // app_rdy held low for 20 cycles in WR_CMD.
    rdy_mode = 2;
    ddr3_app_rdy = 1'b0;
    ddr3_app_wdf_rdy = 1'b1;
    pulse_frame_start();
    for (int i = 0; i < 8; i++) send_pixel(12'($urandom_range(0, 4095)));
    wait_for(P_APP_EN, "app_en");
    expect_refused(20, "wr_cmd_refuses_pixels");
    @(negedge clk);
    check("app_en_after_stall", 64'(ddr3_app_en), 64'd1);
    tick();
    ddr3_app_rdy = 1'b1;
    drain();

    // wdf_rdy low 5 cycles in WR_BEAT0 and 3 cycles in WR_BEAT1.
    ddr3_app_wdf_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send_pixel(12'($urandom_range(0, 4095)));
    wait_for(P_BEAT0, "beat0");
    repeat (4) tick();
    ddr3_app_wdf_rdy = 1'b1;
    tick();
    ddr3_app_wdf_rdy = 1'b0;
    wait_for(P_BEAT1, "beat1");
    repeat (2) tick();
    ddr3_app_wdf_rdy = 1'b1;
    drain();

    // frame_start after 5 pixels, then frame_start deferred across WR_CMD.
    rdy_mode = 0;
    pulse_frame_start();
    for (int i = 0; i < 5; i++) send_pixel(12'($urandom_range(0, 4095)));
    pulse_frame_start();
    for (int i = 0; i < 8; i++) send_pixel(12'($urandom_range(0, 4095)));
    drain();
    rdy_mode = 2;
    ddr3_app_rdy = 1'b0;
    ddr3_app_wdf_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send_pixel(12'($urandom_range(0, 4095)));
    wait_for(P_APP_EN, "app_en_deferred");
    pulse_frame_start();
    repeat (3) tick();
    ddr3_app_rdy = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) send_pixel(12'($urandom_range(0, 4095)));
    drain();

    // rst while in WR_BEAT1.
    rdy_mode = 2;
    ddr3_app_rdy = 1'b1;
    ddr3_app_wdf_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send_pixel(12'($urandom_range(0, 4095)));
    ddr3_app_wdf_rdy = 1'b1;
    tick();
    ddr3_app_wdf_rdy = 1'b0;
    wait_for(P_BEAT1, "beat1_before_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_frame_start();
    @(negedge clk);
    check("midrst_wdf_wren", 64'(ddr3_app_wdf_wren), 64'd0);
    check("midrst_wdf_end", 64'(ddr3_app_wdf_end), 64'd0);
    check("midrst_wdf_data", ddr3_app_wdf_data, 64'd0);
    check("midrst_app_en", 64'(ddr3_app_en), 64'd0);
    check("midrst_app_addr", 64'(ddr3_app_addr), 64'd0);
    check("midrst_render_complete", 64'(render_complete), 64'd0);
    tick();
    rdy_mode = 0;
    expect_refused(5, "post_rst_refuses_pixels");
    pulse_frame_start();
    for (int i = 0; i < 8; i++) send_pixel(12'($urandom_range(0, 4095)));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Upstream neighbour of the VGA scan-out stage.
- Accepts the renderer's raster-order pixel stream as 12-bit RGB444 values and packs each group of 8 pixels into two 64-bit DDR3 write beats.
- Issues one MIG UI write command per 8-pixel group into the framebuffer region.
- Raises render_complete once the last group of the frame has been accepted by DDR3; scan-out waits on that signal before it starts fetching.

Parameters:
- ADDR_WIDTH, 19: DDR3 UI address width; matches FB_ADDR_WIDTH.
- FB_PIXELS, 307200: pixels per frame (640x480); must be a multiple of 8.
- BURST_PIXELS, 8: pixels per write command; fixed at 8 for 2:1 MIG (2 x 64-bit beats).

Ports:
- clk  in  1  DDR3 UI clock (160 MHz).
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle pulse; begin a new frame at address 0.
- pix_valid  in  1  pixel present on pix_data.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
- pix_data  in  12  {b[11:8], g[7:4], r[3:0]}.
- render_complete  out  1  level; frame fully written to DDR3.
- ddr3_app_en  out  1  MIG command valid.
- ddr3_app_cmd  out  3  always 3'b000 (write).
- ddr3_app_addr  out  ADDR_WIDTH  command address (pixel index of first pixel in group).
- ddr3_app_rdy  in  1  MIG command accept.
- ddr3_app_wdf_wren  out  1  write data valid.
- ddr3_app_wdf_data  out  64  write data beat.
- ddr3_app_wdf_end  out  1  last beat of burst.
- ddr3_app_wdf_rdy  in  1  MIG write-data accept.

Behaviour:
- Reset values: state IDLE; all outputs 0; address 0; pixel count 0; render_complete 0.
- Pixel packing:
  - Each pixel is stored as the 16-bit word {4'b0, pix_data}.
  - Group pixel k (k=0..7) goes to beat (k/4), bits [63-16*(k%4) -: 16].
  - Pixel 0 therefore sits in beat0[63:48]; this matches the MSB-first 64->16 read FIFO in scan-out.
- States:
  - IDLE: pix_ready=0. frame_start -> COLLECT; address=0, count=0, render_complete=0.
  - COLLECT: pix_ready=1. Each accepted pixel shifts into the group register and the count increments.
    - On acceptance of the 8th pixel -> WR_BEAT0. No further pixel is accepted in that cycle.
  - WR_BEAT0: wdf_wren=1, wdf_data=beat0, wdf_end=0; hold until wdf_rdy, then -> WR_BEAT1.
  - WR_BEAT1: wdf_wren=1, wdf_data=beat1, wdf_end=1; hold until wdf_rdy, then -> WR_CMD.
  - WR_CMD: app_en=1, app_addr=address; hold until app_rdy.
    - On acceptance: address += 8.
    - If the accepted address was FB_PIXELS-8 -> DONE; otherwise -> COLLECT.
  - DONE: render_complete=1 (held), pix_ready=0. frame_start -> COLLECT, same initialisation as in IDLE.
- Output timing:
  - All DDR3 outputs are registered.
  - app_en and wdf_wren are never deasserted before their rdy.
  - Address and data stay stable while valid is high.
- Throughput: minimum 11 cycles per group (8 collect + 3 handshake) with all rdy signals high.
- frame_start in COLLECT/WR_*:
  - Ignored while a handshake (WR_BEAT0/1, WR_CMD) is pending, to avoid orphaning MIG data.
  - Latched and applied on return to COLLECT: discard partial group, address=0, render_complete=0.
- pix_valid with pix_ready=0 is held off upstream; no pixel loss.
- Address arithmetic is ADDR_WIDTH bits; no wrap within a frame because the final address is FB_PIXELS-8.
- rst mid-burst: immediate return to IDLE, outputs 0. The MIG side is reset together with this block.

Test Plan:
1. Reset, frame_start, pixels 0x001..0x008 with all rdy=1:
   - beat0 = 0x0001_0002_0003_0004, beat1 = 0x0005_0006_0007_0008 with wdf_end on beat1.
   - Then app_en with addr=0; the next group is written at addr=8.
2. Full 307200-pixel frame with random rdy stalls:
   - Exactly 38400 commands; last addr=307192.
   - render_complete rises only after the final app_rdy handshake and stays high.
3. Hold app_rdy=0 for 20 cycles in WR_CMD:
   - app_en/app_addr stable throughout; pix_ready=0; no pixel accepted.
4. wdf_rdy=0 for 5 cycles in WR_BEAT0 and for 3 cycles in WR_BEAT1:
   - Data stable; exactly 2 wren beats are accepted per group.
5. frame_start after 5 pixels of a group:
   - Partial group discarded; next command addr=0 carrying the new 8 pixels.
   - frame_start during WR_CMD is deferred until app_rdy completes.
6. rst asserted in WR_BEAT1:
   - Next cycle all outputs 0, state IDLE.
   - Pixels are refused until frame_start.
